systolic_result_drain: RTL and testbench

Reads back the N×N accumulator results of the systolic multiply array once a product is complete. On a `capture` strobe it snapshots every cell's accumulator output and then streams the values out, one per transfer, in row-major order over a valid/ready interface. The snapshot frees the array to be reset and reloaded while the previous result is still draining. It sits between the array's accumulator outputs and the downstream consumer, such as a bus bridge or result FIFO.

---
 rtl/systolic_result_drain.sv | 62 ++++++
 tb/tb_systolic_result_drain.sv | 137 +++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the N x N accumulator array on capture and
// streams the words out row-major over valid/ready, freeing the array at once.
module systolic_result_drain #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int IW   = $clog2(N)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 capture_i,
  input  logic [N*N*WIDTH-1:0] z_flat_i,
  output logic                 busy_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [IW-1:0]        out_row_o,
  output logic [IW-1:0]        out_col_o,
  output logic                 out_last_o,
  output logic                 dropped_o
);
  localparam int CW = $clog2(N*N);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t               state_q;
  logic [CW-1:0]        idx_q;
  logic [N*N*WIDTH-1:0] buf_q;
  logic                 drop_q;
  logic                 stream, last;
  assign stream      = state_q == STREAM;
  assign last        = idx_q == CW'(N*N-1);
  assign busy_o      = stream;
  assign out_valid_o = stream;
  assign out_last_o  = stream && last;
  assign dropped_o   = drop_q;
  assign out_data_o  = stream ? buf_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
  assign out_row_o   = stream ? IW'(int'(idx_q) / N) : '0;
  assign out_col_o   = stream ? IW'(int'(idx_q) % N) : '0;
  // A capture landing on the last-transfer edge reloads and keeps streaming.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (!stream) begin
        if (capture_i) begin
          buf_q   <= z_flat_i;
          idx_q   <= '0;
          state_q <= STREAM;
        end
      end else if (out_ready_i && last) begin
        idx_q <= '0;
        if (capture_i) buf_q <= z_flat_i;
        else state_q <= IDLE;
      end else begin
        if (out_ready_i) idx_q <= idx_q + 1'b1;
        drop_q <= capture_i;
      end
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: table-driven cycle vectors on an N=2 instance plus
// hand sequences for async reset and an N=4 width-extremes drain.
module tb_systolic_result_drain;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic        cap2, rdy2, busy2, v2, row2, col2, last2, drop2;
  logic [63:0] z2;
  logic [15:0] d2;
  logic        cap4, rdy4, busy4, v4, last4, drop4;
  logic [255:0] z4;
  logic [15:0] d4;
  logic [1:0]  row4, col4;
  int checks = 0;
  int failures = 0;

  systolic_result_drain #(.N(2), .WIDTH(16)) dut2 (
    .clock_i(clk), .reset_i(rst), .capture_i(cap2), .z_flat_i(z2), .busy_o(busy2),
    .out_valid_o(v2), .out_ready_i(rdy2), .out_data_o(d2), .out_row_o(row2),
    .out_col_o(col2), .out_last_o(last2), .dropped_o(drop2));

  systolic_result_drain #(.N(4), .WIDTH(16)) dut4 (
    .clock_i(clk), .reset_i(rst), .capture_i(cap4), .z_flat_i(z4), .busy_o(busy4),
    .out_valid_o(v4), .out_ready_i(rdy4), .out_data_o(d4), .out_row_o(row4),
    .out_col_o(col4), .out_last_o(last4), .dropped_o(drop4));

  typedef struct {
    logic       cap, rdy;
    logic [1:0] zs;
    logic       v;
    logic [15:0] d;
    logic       r, c, l, b, dr;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] zval(input logic [1:0] s);
    return s == 2'd0 ? {16'd11, 16'd9, 16'd7, 16'd5} :
           s == 2'd1 ? {64{1'b1}} : {16'd4, 16'd3, 16'd2, 16'd1};
  endfunction

  task automatic add(input logic cap, rdy, input logic [1:0] zs, input logic v,
                     input logic [15:0] d, input logic r, c, l, dr);
    vq.push_back('{cap, rdy, zs, v, d, r, c, l, v, dr});
  endtask

  logic [15:0] w4 [16];

  initial begin
    // basic drain
    add(1,1,0, 1, 5,0,0,0,0); add(0,1,0, 1, 7,0,1,0,0); add(0,1,0, 1, 9,1,0,0,0);
    add(0,1,0, 1,11,1,1,1,0); add(0,1,0, 0, 0,0,0,0,0); add(0,1,0, 0, 0,0,0,0,0);
    // backpressure
    add(1,0,0, 1, 5,0,0,0,0); add(0,1,0, 1, 7,0,1,0,0); add(0,0,0, 1, 7,0,1,0,0);
    add(0,0,0, 1, 7,0,1,0,0); add(0,1,0, 1, 9,1,0,0,0); add(0,1,0, 1,11,1,1,1,0);
    add(0,0,0, 1,11,1,1,1,0); add(0,1,0, 0, 0,0,0,0,0);
    // snapshot isolation
    add(1,1,0, 1, 5,0,0,0,0); add(0,1,1, 1, 7,0,1,0,0); add(0,1,1, 1, 9,1,0,0,0);
    add(0,1,1, 1,11,1,1,1,0); add(0,1,1, 0, 0,0,0,0,0);
    // ignored capture, then capture on the last transfer
    add(1,1,0, 1, 5,0,0,0,0); add(0,1,0, 1, 7,0,1,0,0); add(1,0,0, 1, 7,0,1,0,1);
    add(0,1,0, 1, 9,1,0,0,0); add(0,1,0, 1,11,1,1,1,0); add(1,1,2, 1, 1,0,0,0,0);
    add(0,1,2, 1, 2,0,1,0,0); add(0,1,2, 1, 3,1,0,0,0); add(0,1,2, 1, 4,1,1,1,0);
    add(0,1,2, 0, 0,0,0,0,0);

    rst = 1'b1; cap2 = 0; rdy2 = 0; z2 = '0; cap4 = 0; rdy4 = 0; z4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, v2}, 0);
    chk("rst_busy", {31'd0, busy2}, 0);
    chk("rst_data", {16'd0, d2}, 0);
    chk("rst_last_drop", {30'd0, last2, drop2}, 0);
    chk("rst_rowcol", {30'd0, row2, col2}, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      cap2 = vq[i].cap; rdy2 = vq[i].rdy; z2 = zval(vq[i].zs);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, v2}, {31'd0, vq[i].v});
      chk($sformatf("v%0d_data", i), {16'd0, d2}, {16'd0, vq[i].d});
      chk($sformatf("v%0d_rowcol", i), {30'd0, row2, col2}, {30'd0, vq[i].r, vq[i].c});
      chk($sformatf("v%0d_last", i), {31'd0, last2}, {31'd0, vq[i].l});
      chk($sformatf("v%0d_busy", i), {31'd0, busy2}, {31'd0, vq[i].b});
      chk($sformatf("v%0d_dropped", i), {31'd0, drop2}, {31'd0, vq[i].dr});
    end

    // asynchronous reset after word 7 transfers
    @(negedge clk); cap2 = 1; rdy2 = 1; z2 = zval(0);
    @(posedge clk); #1; cap2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_data", {16'd0, d2}, 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, v2}, 0);
    chk("arst_busy", {31'd0, busy2}, 0);
    chk("arst_data", {16'd0, d2}, 0);
    chk("arst_rowcol", {30'd0, row2, col2}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); cap2 = 1; rdy2 = 0;
    @(posedge clk); #1;
    chk("post_rst_data", {16'd0, d2}, 5);
    chk("post_rst_rowcol", {30'd0, row2, col2}, 0);
    @(negedge clk); cap2 = 0;

    // N=4 width extremes
    for (int i = 0; i < 16; i++) begin
      w4[i] = i == 0 ? 16'hFFFF : i == 5 ? 16'h0000 : 16'h8000 | 16'(i * 16'h0111);
      z4[i*16 +: 16] = w4[i];
    end
    @(negedge clk); cap4 = 1; rdy4 = 1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("n4_%0d_data", i), {16'd0, d4}, {16'd0, w4[i]});
      chk($sformatf("n4_%0d_rowcol", i), {28'd0, row4, col4}, 32'(((i / 4) << 2) | (i % 4)));
      chk($sformatf("n4_%0d_vl", i), {30'd0, v4, last4}, {30'd0, 1'b1, i == 15});
      if (i == 0) begin
        cap4 = 0;
        z4 = '0;
      end
    end
    @(posedge clk); #1;
    chk("n4_end_valid", {30'd0, v4, busy4}, 0);
    chk("n4_end_data", {16'd0, d4}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
